// File: rtl/romload_pkg.sv
// Shared definitions for the ROM-load streamer: FSM encoding, control-word
// bit positions and status-word field offsets.
package romload_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  // Control word layout
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CHAN_LSB  = 8;

  // Status word layout: {loading, state[1:0], fifo_full, 4'b0, byte_cnt[23:0]}
  localparam int STAT_LOADING   = 31;
  localparam int STAT_STATE_LSB = 29;
  localparam int STAT_FULL      = 28;
  localparam int STAT_BCNT_LSB  = 0;
  localparam int BCNT_W         = 24;

endpackage

// File: rtl/romload_fifo.sv
// Data-word FIFO with a registered occupancy count. Full/empty come from the
// registered count, so a push is refused when full even if a pop happens in
// the same cycle. Flush empties the FIFO and wins over push/pop.
module romload_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_q];

  // Pointer and count update
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the count
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/romload_streamer.sv
// ROM-load streamer: CPU writes a start control word, HDR_WORDS header words,
// then data words that are queued and serialized little-endian into OUT_W-bit
// beats. A stop control word drains the queue and returns to IDLE.
// Optional feature: define ROMLOAD_CHECKSUM_EN for a 16-bit running byte sum.
module romload_streamer
  import romload_pkg::*;
#(
  parameter int  HDR_WORDS  = 3,
  parameter int  FIFO_DEPTH = 8,
  parameter int  OUT_W      = 8,
  parameter int  NCHAN      = 2,
  localparam int CW         = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                    wclk,
  input  logic                    resetn,
  input  logic                    reg_ctrl_we,
  input  logic [31:0]             reg_ctrl_di,
  input  logic                    reg_data_we,
  input  logic [31:0]             reg_data_di,
  output logic                    reg_data_wait,
  output logic [31:0]             reg_stat_do,
  output logic                    loading,
  output logic [CW-1:0]           chan,
  output logic [HDR_WORDS*32-1:0] hdr,
  output logic                    hdr_valid,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             checksum
);
  localparam int         NBEATS    = 32 / OUT_W;
  localparam logic [1:0] LAST_BEAT = 2'(NBEATS - 1);
  localparam logic [2:0] LAST_HDR  = 3'(HDR_WORDS - 1);

  logic [1:0] rst_pipe_q;
  logic       rst_n_i;

  state_e                  state_q, state_d;
  logic                    loading_q, loading_d;
  logic [CW-1:0]           chan_q, chan_d;
  logic [HDR_WORDS*32-1:0] hdr_q, hdr_d;
  logic [2:0]              hdr_idx_q, hdr_idx_d;
  logic                    hdr_valid_q, hdr_valid_d;
  logic [31:0]             sh_q, sh_d;
  logic [1:0]              beat_q, beat_d;
  logic                    out_valid_q, out_valid_d;
  logic [BCNT_W-1:0]       bcnt_q, bcnt_d;

  logic        start, stop, beat_fire, ser_last;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0] fifo_dout;
  logic        ctrl_unused;

  // Reset asserts asynchronously, releases two wclk edges after resetn rises
  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn) rst_pipe_q <= '0;
    else         rst_pipe_q <= {rst_pipe_q[0], 1'b1};
  end
  assign rst_n_i = rst_pipe_q[1];

  assign ctrl_unused = ^reg_ctrl_di;
  assign start = reg_ctrl_we & reg_ctrl_di[CTRL_START_BIT];
  assign stop  = reg_ctrl_we & ~reg_ctrl_di[CTRL_START_BIT] &
                 ((state_q == ST_HEADER) | (state_q == ST_DATA));

  // Writes outside DATA never stall; in DATA a full FIFO holds the CPU off
  assign reg_data_wait = reg_data_we & (state_q == ST_DATA) & fifo_full;
  assign fifo_push     = reg_data_we & (state_q == ST_DATA) & ~start;

  // Refill the serializer when idle, or on its last beat so beats stay back-to-back
  assign beat_fire = out_valid_q & out_ready;
  assign ser_last  = (beat_q == LAST_BEAT);
  assign fifo_pop  = ~fifo_empty & (~out_valid_q | (beat_fire & ser_last)) & ~start;

  romload_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (wclk),
    .rst_n (rst_n_i),
    .flush (start),
    .push  (fifo_push),
    .din   (reg_data_di),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM next-state, header capture and loading flag
  always_comb begin
    state_d     = state_q;
    loading_d   = loading_q;
    chan_d      = chan_q;
    hdr_d       = hdr_q;
    hdr_idx_d   = hdr_idx_q;
    hdr_valid_d = 1'b0;
    if (start) begin
      state_d   = ST_HEADER;
      loading_d = 1'b1;
      chan_d    = reg_ctrl_di[CTRL_CHAN_LSB +: CW];
      hdr_idx_d = '0;
    end else begin
      case (state_q)
        ST_HEADER: begin
          if (stop) begin
            state_d = ST_DRAIN;
          end else if (reg_data_we) begin
            for (int w = 0; w < HDR_WORDS; w++)
              if (hdr_idx_q == 3'(w)) hdr_d[w*32 +: 32] = reg_data_di;
            hdr_idx_d = hdr_idx_q + 1'b1;
            if (hdr_idx_q == LAST_HDR) begin
              state_d     = ST_DATA;
              hdr_valid_d = 1'b1;
            end
          end
        end
        ST_DATA:  if (stop) state_d = ST_DRAIN;
        ST_DRAIN: begin
          if (fifo_empty && !out_valid_q) begin
            state_d   = ST_IDLE;
            loading_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Serializer and byte counter
  always_comb begin
    sh_d        = sh_q;
    beat_d      = beat_q;
    out_valid_d = out_valid_q;
    bcnt_d      = bcnt_q;
    if (start) begin
      out_valid_d = 1'b0;
      beat_d      = '0;
      bcnt_d      = '0;
    end else begin
      if (beat_fire) begin
        bcnt_d = bcnt_q + BCNT_W'(OUT_W / 8);
        sh_d   = sh_q >> OUT_W;
        beat_d = beat_q + 1'b1;
        if (ser_last) out_valid_d = 1'b0;
      end
      if (fifo_pop) begin
        sh_d        = fifo_dout;
        beat_d      = '0;
        out_valid_d = 1'b1;
      end
    end
  end

  // Control and serializer registers
  always_ff @(posedge wclk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      loading_q   <= 1'b0;
      chan_q      <= '0;
      hdr_q       <= '0;
      hdr_idx_q   <= '0;
      hdr_valid_q <= 1'b0;
      sh_q        <= '0;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      bcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      loading_q   <= loading_d;
      chan_q      <= chan_d;
      hdr_q       <= hdr_d;
      hdr_idx_q   <= hdr_idx_d;
      hdr_valid_q <= hdr_valid_d;
      sh_q        <= sh_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      bcnt_q      <= bcnt_d;
    end
  end

`ifdef ROMLOAD_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  // Wrapping sum of every delivered byte since the last start
  always_comb begin
    csum_d = csum_q;
    if (start) csum_d = '0;
    else if (beat_fire)
      for (int b = 0; b < OUT_W / 8; b++) csum_d = csum_d + {8'h00, out_data[b*8 +: 8]};
  end

  // Checksum register
  always_ff @(posedge wclk or negedge rst_n_i) begin
    if (!rst_n_i) csum_q <= '0;
    else          csum_q <= csum_d;
  end
  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

  // Status word assembly
  always_comb begin
    reg_stat_do                               = '0;
    reg_stat_do[STAT_LOADING]                 = loading_q;
    reg_stat_do[STAT_STATE_LSB +: 2]          = state_q;
    reg_stat_do[STAT_FULL]                    = fifo_full;
    reg_stat_do[STAT_BCNT_LSB +: BCNT_W]      = bcnt_q;
  end

  assign loading   = loading_q;
  assign chan      = chan_q;
  assign hdr       = hdr_q;
  assign hdr_valid = hdr_valid_q;
  assign out_data  = sh_q[OUT_W-1:0];
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_romload_streamer.sv
// Directed bench for romload_streamer: table-driven main flow on the default
// build, plus sequences for back-pressure, 16-bit beats, random ready, flush
// on restart and the optional checksum.
`timescale 1ns/1ps
module tb_romload_streamer;
`ifdef ROMLOAD_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic wclk = 1'b0, resetn = 1'b0;
  always #5 wclk = ~wclk;

  logic ctrl_we = 0, data_we = 0, out_ready = 0, en8 = 1, en16 = 0;
  logic [31:0] ctrl_di = '0, data_di = '0;

  logic wait8, ld8, hv8, ov8;  logic [31:0] stat8; logic [0:0] chan8;
  logic [95:0] hdr8; logic [7:0] od8; logic [15:0] cs8;
  logic wait16, ld16, hv16, ov16; logic [31:0] stat16; logic [0:0] chan16;
  logic [95:0] hdr16; logic [15:0] od16; logic [15:0] cs16;

  romload_streamer u_dut (
    .wclk(wclk), .resetn(resetn),
    .reg_ctrl_we(ctrl_we & en8), .reg_ctrl_di(ctrl_di),
    .reg_data_we(data_we & en8), .reg_data_di(data_di), .reg_data_wait(wait8),
    .reg_stat_do(stat8), .loading(ld8), .chan(chan8), .hdr(hdr8), .hdr_valid(hv8),
    .out_data(od8), .out_valid(ov8), .out_ready(out_ready), .checksum(cs8));

  romload_streamer #(.OUT_W(16)) u_dut16 (
    .wclk(wclk), .resetn(resetn),
    .reg_ctrl_we(ctrl_we & en16), .reg_ctrl_di(ctrl_di),
    .reg_data_we(data_we & en16), .reg_data_di(data_di), .reg_data_wait(wait16),
    .reg_stat_do(stat16), .loading(ld16), .chan(chan16), .hdr(hdr16), .hdr_valid(hv16),
    .out_data(od16), .out_valid(ov16), .out_ready(out_ready), .checksum(cs16));

  wire s_wait = en16 ? wait16 : wait8;
  wire s_ld   = en16 ? ld16 : ld8;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    n_total++;
    $display("FAIL %s: timed out", nm);
  endtask

  // Output monitor, sampled on the falling edge
  logic [7:0]  q8[$];
  logic [15:0] q16[$];
  int t16[$];
  int cyc = 0;
  bit stab_en = 0, stall_p = 0;
  logic [7:0] stall_d;
  always @(posedge wclk) cyc <= cyc + 1;
  always @(negedge wclk) begin
    if (stab_en && stall_p) begin
      chk("stall_valid_held", ov8, 1'b1);
      chk("stall_data_held", od8, stall_d);
    end
    stall_p = ov8 && !out_ready;
    stall_d = od8;
    if (en8 && ov8 && out_ready) q8.push_back(od8);
    if (en16 && ov16 && out_ready) begin q16.push_back(od16); t16.push_back(cyc); end
  end

  task automatic tick(); @(posedge wclk); #1; endtask

  task automatic ctrl(input logic [31:0] di);
    ctrl_we = 1; ctrl_di = di; tick(); ctrl_we = 0;
  endtask

  task automatic dwrite(input logic [31:0] di);
    int n = 0;
    data_we = 1; data_di = di;
    while (s_wait && n < 300) begin tick(); n++; end
    if (s_wait) fail("dwrite_wait");
    tick(); data_we = 0;
  endtask

  task automatic send_hdr(input logic [31:0] h0, input logic [31:0] h1, input logic [31:0] h2);
    dwrite(h0); dwrite(h1); dwrite(h2);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (s_ld && n < bound) begin tick(); n++; end
    if (s_ld) fail("wait_idle");
  endtask

  function automatic int mism(input logic [7:0] a[$], input logic [7:0] b[$]);
    int m = 0;
    if (a.size() != b.size()) return -1;
    foreach (a[i]) if (a[i] !== b[i]) m++;
    return m;
  endfunction

  typedef struct {
    bit          is_ctrl;
    logic [31:0] di;
    logic [1:0]  st;
    bit          ld;
    bit          hv;
  } vec_t;
  vec_t tv[6];

  // Watchdog
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  exp8[$];
    logic [31:0] w;
    logic [15:0] csum;
    int n;

    tv[0] = '{1, 32'h0000_0101, 2'd1, 1, 0};
    tv[1] = '{0, 32'h0000_0021, 2'd1, 1, 0};
    tv[2] = '{0, 32'h001F_FFFF, 2'd1, 1, 0};
    tv[3] = '{0, 32'h0000_1FFF, 2'd2, 1, 1};
    tv[4] = '{0, 32'h4433_2211, 2'd2, 1, 0};
    tv[5] = '{1, 32'h0000_0000, 2'd3, 1, 0};

    // Reset values
    tick(); tick();
    chk("rst_stat", stat8, 32'h0);
    chk("rst_out_valid", ov8, 1'b0);
    chk("rst_hdr_valid", hv8, 1'b0);
    chk("rst_hdr", hdr8, 96'h0);
    chk("rst_chan", chan8, 1'b0);
    chk("rst_checksum", cs8, 16'h0);
    chk("rst_wait", wait8, 1'b0);

    // A start on the first edge after release is still held by the synchroniser
    @(negedge wclk); resetn = 1;
    ctrl(32'h0000_0101);
    chk("sync_hold_stat", stat8, 32'h0);
    tick();

    // Data write in IDLE: no stall, no effect
    data_we = 1; data_di = 32'hDEAD_BEEF;
    chk("idle_wait", wait8, 1'b0);
    tick(); data_we = 0;
    chk("idle_noeffect", stat8, 32'h0);
    chk("idle_no_beat", ov8, 1'b0);

    // Main flow from the table
    out_ready = 1; q8.delete();
    for (int i = 0; i < 6; i++) begin
      if (tv[i].is_ctrl) ctrl(tv[i].di); else dwrite(tv[i].di);
      chk($sformatf("tv%0d_state", i), stat8[30:29], tv[i].st);
      chk($sformatf("tv%0d_loading", i), ld8, tv[i].ld);
      chk($sformatf("tv%0d_hdr_valid", i), hv8, tv[i].hv);
    end
    wait_idle(50);
    chk("main_beats_at_idle", q8.size(), 4);
    exp8 = '{8'h11, 8'h22, 8'h33, 8'h44};
    chk("main_stream", mism(q8, exp8), 0);
    chk("main_byte_cnt", stat8[23:0], 24'd4);
    chk("main_hdr", hdr8, {32'h0000_1FFF, 32'h001F_FFFF, 32'h0000_0021});
    chk("main_chan", chan8, 1'b1);
    chk("main_state_idle", stat8[30:29], 2'd0);
    chk("main_checksum", cs8, CS_EN ? 16'h00AA : 16'h0);

    // Back-pressure: serializer holds word 1, FIFO holds words 2..9, word 10 stalls
    out_ready = 0; q8.delete(); exp8.delete();
    ctrl(32'h1);
    send_hdr(32'h1, 32'h2, 32'h3);
    for (int i = 0; i < 9; i++) begin
      w = 32'hA000_0000 + 32'(i * 32'h0101_0101);
      for (int b = 0; b < 4; b++) exp8.push_back(w[b*8 +: 8]);
      data_we = 1; data_di = w;
      chk($sformatf("fill%0d_wait", i), wait8, 1'b0);
      tick();
    end
    w = 32'h5566_7788;
    for (int b = 0; b < 4; b++) exp8.push_back(w[b*8 +: 8]);
    data_di = w;
    for (int i = 0; i < 3; i++) begin
      chk("full_wait", wait8, 1'b1);
      chk("full_flag", stat8[28], 1'b1);
      tick();
    end
    out_ready = 1;
    n = 0;
    while (wait8 && n < 40) begin tick(); n++; end
    if (wait8) fail("full_release");
    tick(); data_we = 0;
    ctrl(32'h0);
    wait_idle(200);
    chk("bp_stream", mism(q8, exp8), 0);
    chk("bp_byte_cnt", stat8[23:0], 24'd40);

    // 16-bit beats, back-to-back across the word boundary
    en8 = 0; en16 = 1; q16.delete(); t16.delete();
    ctrl(32'h1);
    send_hdr(32'h1, 32'h2, 32'h3);
    dwrite(32'hAABB_CCDD);
    dwrite(32'h1122_3344);
    ctrl(32'h0);
    wait_idle(50);
    if (q16.size() == 4) begin
      chk("w16_beats", {q16[0], q16[1], q16[2], q16[3]}, 64'hCCDD_AABB_3344_1122);
      chk("w16_consecutive", t16[3] - t16[0], 3);
    end else chk("w16_count", q16.size(), 4);
    chk("w16_byte_cnt", stat16[23:0], 24'd8);
    en16 = 0; en8 = 1;

    // Random ready over 256 words
    out_ready = 0; q8.delete(); exp8.delete(); csum = '0;
    ctrl(32'h1);
    send_hdr(32'h7, 32'h8, 32'h9);
    stab_en = 1;
    begin
      bit done = 0;
      fork
        begin
          for (int i = 0; i < 256; i++) begin
            w = $urandom;
            for (int b = 0; b < 4; b++) begin
              exp8.push_back(w[b*8 +: 8]);
              csum = csum + {8'h00, w[b*8 +: 8]};
            end
            dwrite(w);
          end
          ctrl(32'h0);
          wait_idle(20000);
          done = 1;
        end
        begin
          while (!done) begin out_ready = 1'($urandom_range(0, 1)); tick(); end
        end
      join
    end
    stab_en = 0; out_ready = 1;
    chk("rnd_count", q8.size(), 1024);
    chk("rnd_stream", mism(q8, exp8), 0);
    chk("rnd_byte_cnt", stat8[23:0], 24'd1024);
    chk("rnd_checksum", cs8, CS_EN ? csum : 16'h0);

    // Restart mid-DATA with 5 words queued
    out_ready = 0;
    ctrl(32'h1);
    send_hdr(32'h1, 32'h2, 32'h3);
    for (int i = 0; i < 5; i++) dwrite(32'hBEEF_0000 + 32'(i));
    out_ready = 1; tick(); out_ready = 0;
    chk("flush_pre_bcnt", stat8[23:0], 24'd1);
    chk("flush_pre_valid", ov8, 1'b1);
    ctrl(32'h0000_0001);
    chk("flush_valid", ov8, 1'b0);
    chk("flush_bcnt", stat8[23:0], 24'd0);
    chk("flush_state", stat8[30:29], 2'd1);
    chk("flush_chan", chan8, 1'b0);
    q8.delete();
    send_hdr(32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003);
    chk("flush_hdr_valid", hv8, 1'b1);
    chk("flush_hdr", hdr8, {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001});
    out_ready = 1;
    dwrite(32'h0D0C_0B0A);
    ctrl(32'h0);
    wait_idle(50);
    exp8 = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    chk("flush_stream", mism(q8, exp8), 0);
    chk("flush_checksum", cs8, CS_EN ? 16'h002E : 16'h0);

    // Checksum wrap on all-ones data
    ctrl(32'h1);
    send_hdr(32'h1, 32'h2, 32'h3);
    dwrite(32'hFFFF_FFFF);
    dwrite(32'hFFFF_FFFF);
    ctrl(32'h0);
    wait_idle(50);
    chk("cs_ff_checksum", cs8, CS_EN ? 16'h07F8 : 16'h0);
    chk("cs_ff_byte_cnt", stat8[23:0], 24'd8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
